lrm_sample_feeder: RTL and testbench

- Initiator-side driver for the lrm regression core: streams packed (Xi, Yi, PREDICT) samples into lrm whenever lrm raises READY.
- Collects each DONE result (Yp, A, B) into a result FIFO and tracks training count, outstanding predictions and run cycle count.
- Sits between a host/loader and lrm. It replaces the bench-side stimulus path in system-level runs.

---
 rtl/lrm_sample_feeder_pkg.sv | 28 ++
 rtl/lrm_sample_feeder_if.sv | 25 ++
 rtl/lrm_sync_fifo.sv | 69 ++++++
 rtl/lrm_sample_feeder.sv | 167 ++++++++++++++++
 tb/tb_lrm_sample_feeder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lrm_sample_feeder_pkg.sv
// Shared widths, bit positions, result layout and FSM encodings for the lrm sample feeder.
package lrm_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SAMPLE_W  = 17;
    localparam int unsigned RESULT_W  = 25;
    localparam int unsigned CYCLE_W   = 32;

    // Sample word layout: {Xi, Yi, PREDICT}
    localparam int unsigned X_MSB     = 16;
    localparam int unsigned Y_MSB     = 8;
    localparam int unsigned PRED_BIT  = 0;

    // Fit is considered meaningful once this many training samples were sent
    localparam int unsigned MIN_TRAIN = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic              fit_ok;
        logic [DATA_W-1:0] yp;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } result_t;

endpackage

// File: rtl/lrm_sample_feeder_if.sv
// Link between the sample feeder (master) and the lrm core (slave).
interface lrm_sample_feeder_if;
    import lrm_pkg::*;

    logic              ready;
    logic [DATA_W-1:0] xi;
    logic [DATA_W-1:0] yi;
    logic              predict;
    logic              valid;
    logic              done;
    logic [DATA_W-1:0] yp;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    modport master (
        input  ready, done, yp, a, b,
        output xi, yi, predict, valid
    );

    modport slave (
        output ready, done, yp, a, b,
        input  xi, yi, predict, valid
    );

endinterface

// File: rtl/lrm_sync_fifo.sv
// Show-ahead synchronous FIFO; push while full and pop while empty are ignored.
module lrm_sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            empty <= (count_next == CW'(0));
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/lrm_sample_feeder.sv
// Streams queued (Xi, Yi, PREDICT) samples into lrm and collects its results.
// Optional build macro LRM_FEED_TRISTATE_EN: XI/YI/PREDICT float when no live sample.
module lrm_sample_feeder
    import lrm_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned RES_DEPTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 WR_EN,
    input  logic [SAMPLE_W-1:0]  WR_DATA,
    output logic                 FULL,
    lrm_sample_feeder_if.master  lrm,
    input  logic                 RD_EN,
    output logic [RESULT_W-1:0]  RD_DATA,
    output logic                 RES_EMPTY,
    output logic [DATA_W-1:0]    TRAIN_CNT,
    output logic [DATA_W-1:0]    OUTSTANDING,
    output logic [CYCLE_W-1:0]   CYCLES,
    output logic                 BUSY,
    output logic                 FINISHED,
    output logic                 ERR
);

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                finished_next;
    logic [SAMPLE_W-1:0] s_head;
    logic                s_empty;
    logic                r_full;
    logic                valid_c;
    logic                xfer_c;
    logic                start_c;
    logic                fit_ok_c;
    logic [DATA_W-1:0]   head_xi;
    logic [DATA_W-1:0]   head_yi;
    logic                head_pred;
    result_t             res_word;

    assign head_xi   = s_head[X_MSB -: DATA_W];
    assign head_yi   = s_head[Y_MSB -: DATA_W];
    assign head_pred = s_head[PRED_BIT];

    assign valid_c  = (state == ST_STREAM) && !s_empty;
    assign xfer_c   = valid_c && lrm.ready;
    assign start_c  = START && (state == ST_IDLE);
    assign fit_ok_c = (TRAIN_CNT >= DATA_W'(MIN_TRAIN));
    assign res_word = {fit_ok_c, lrm.yp, lrm.a, lrm.b};

    assign lrm.valid = valid_c;

    // Sample payload toward lrm: live head or idle value
`ifdef LRM_FEED_TRISTATE_EN
    assign lrm.xi      = valid_c ? head_xi   : 'z;
    assign lrm.yi      = valid_c ? head_yi   : 'z;
    assign lrm.predict = valid_c ? head_pred : 1'bz;
`else
    assign lrm.xi      = valid_c ? head_xi   : '0;
    assign lrm.yi      = valid_c ? head_yi   : '0;
    assign lrm.predict = valid_c ? head_pred : 1'b0;
`endif

    lrm_sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_sample_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (WR_EN),
        .din   (WR_DATA),
        .pop   (xfer_c),
        .dout  (s_head),
        .full  (FULL),
        .empty (s_empty)
    );

    lrm_sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (lrm.done),
        .din   (res_word),
        .pop   (RD_EN),
        .dout  (RD_DATA),
        .full  (r_full),
        .empty (RES_EMPTY)
    );

    // Next-state logic; DRAIN waits until every prediction has come back
    always_comb begin
        state_next    = state;
        finished_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (s_empty) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((OUTSTANDING == '0) && !lrm.done) begin
                    state_next    = ST_IDLE;
                    finished_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status flags
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            BUSY     <= 1'b0;
            FINISHED <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_next;
            BUSY     <= (state_next != ST_IDLE);
            FINISHED <= finished_next;
            if ((WR_EN && FULL) || (lrm.done && r_full)) begin
                ERR <= 1'b1;
            end
        end
    end

    // Run statistics: cycle count, training count, predictions in flight
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CYCLES      <= '0;
            TRAIN_CNT   <= '0;
            OUTSTANDING <= '0;
        end else if (start_c) begin
            CYCLES      <= '0;
            TRAIN_CNT   <= '0;
            OUTSTANDING <= '0;
        end else begin
            if (state != ST_IDLE) begin
                CYCLES <= CYCLES + CYCLE_W'(1);
            end
            if (xfer_c && !head_pred && (TRAIN_CNT != {DATA_W{1'b1}})) begin
                TRAIN_CNT <= TRAIN_CNT + DATA_W'(1);
            end
            case ({xfer_c && head_pred, lrm.done})
                2'b10: OUTSTANDING <= OUTSTANDING + DATA_W'(1);
                2'b01: begin
                    if (OUTSTANDING != '0) begin
                        OUTSTANDING <= OUTSTANDING - DATA_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lrm_sample_feeder.sv
// Self-checking bench for lrm_sample_feeder with sample and result scoreboards.
module tb_lrm_sample_feeder;
    import lrm_pkg::*;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned RES_DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          START;
    logic          WR_EN;
    logic [16:0]   WR_DATA;
    logic          FULL;
    logic          RD_EN;
    logic [24:0]   RD_DATA;
    logic          RES_EMPTY;
    logic [7:0]    TRAIN_CNT;
    logic [7:0]    OUTSTANDING;
    logic [31:0]   CYCLES;
    logic          BUSY;
    logic          FINISHED;
    logic          ERR;

    lrm_sample_feeder_if bus ();

    lrm_sample_feeder #(
        .DEPTH     (DEPTH),
        .RES_DEPTH (RES_DEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .WR_EN       (WR_EN),
        .WR_DATA     (WR_DATA),
        .FULL        (FULL),
        .lrm         (bus.master),
        .RD_EN       (RD_EN),
        .RD_DATA     (RD_DATA),
        .RES_EMPTY   (RES_EMPTY),
        .TRAIN_CNT   (TRAIN_CNT),
        .OUTSTANDING (OUTSTANDING),
        .CYCLES      (CYCLES),
        .BUSY        (BUSY),
        .FINISHED    (FINISHED),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [16:0] exp_s[$];
    logic [24:0] exp_r[$];
    int          m_train   = 0;
    int          xfer_cnt  = 0;
    int          valid_cnt = 0;
    logic [16:0] mon_e;
    logic [7:0]  idle_x;

`ifdef LRM_FEED_TRISTATE_EN
    initial idle_x = 8'bz;
`else
    initial idle_x = 8'h00;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_sample(input logic [7:0] x, input logic [7:0] y, input logic p, input bit keep);
        WR_EN   = 1'b1;
        WR_DATA = {x, y, p};
        if (keep) exp_s.push_back({x, y, p});
        step();
        WR_EN = 1'b0;
    endtask

    task automatic drive_done(input logic [7:0] yp, input logic [7:0] a, input logic [7:0] b, input bit keep);
        bus.done = 1'b1;
        bus.yp   = yp;
        bus.a    = a;
        bus.b    = b;
        if (keep) exp_r.push_back({(m_train >= 2) ? 1'b1 : 1'b0, yp, a, b});
        step();
        bus.done = 1'b0;
    endtask

    task automatic read_result(input string tag);
        if (exp_r.size() == 0) begin
            check_eq({tag, "_none"}, 32'(RES_EMPTY), 32'd1);
        end else begin
            check_eq({tag, "_empty"}, 32'(RES_EMPTY), 32'd0);
            check_eq(tag, 32'(RD_DATA), 32'(exp_r.pop_front()));
        end
        RD_EN = 1'b1;
        step();
        RD_EN = 1'b0;
    endtask

    task automatic pulse_start();
        START   = 1'b1;
        m_train = 0;
        step();
        START = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && BUSY === 1'b1; i++) step();
        check_eq("idle_timeout", 32'(BUSY), 32'd0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        exp_s.delete();
        exp_r.delete();
        m_train = 0;
        step();
        RESET_N = 1'b1;
        step();
    endtask

    // Monitor: score every transfer (VALID && READY) at the falling edge
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (bus.valid === 1'b1) valid_cnt++;
            if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                xfer_cnt++;
                if (exp_s.size() == 0) begin
                    check_eq("xfer_extra", 32'(exp_s.size()), 32'd1);
                end else begin
                    mon_e = exp_s.pop_front();
                    check_eq("xfer_data", 32'({bus.xi, bus.yi, bus.predict}), 32'(mon_e));
                    if (!mon_e[0]) m_train++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        logic pat [5];
        RESET_N  = 1'b0;
        START    = 1'b0;
        WR_EN    = 1'b0;
        WR_DATA  = '0;
        RD_EN    = 1'b0;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        bus.yp    = '0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();

        // Reset state
        check_eq("rst_full", 32'(FULL), 32'd0);
        check_eq("rst_res_empty", 32'(RES_EMPTY), 32'd1);
        check_eq("rst_rd_data", 32'(RD_DATA), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_finished", 32'(FINISHED), 32'd0);
        check_eq("rst_err", 32'(ERR), 32'd0);
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_xi", 32'(bus.xi), 32'(idle_x));
        check_eq("rst_train", 32'(TRAIN_CNT), 32'd0);
        check_eq("rst_out", 32'(OUTSTANDING), 32'd0);
        check_eq("rst_cycles", CYCLES, 32'd0);
        RESET_N = 1'b1;
        step();

        // Basic run: two training samples, one prediction, READY held high
        push_sample(8'd10, 8'd20, 1'b0, 1);
        push_sample(8'd20, 8'd40, 1'b0, 1);
        push_sample(8'd15, 8'd0,  1'b1, 1);
        check_eq("idle_xi_loaded", 32'(bus.xi), 32'(idle_x));
        bus.ready = 1'b1;
        valid_cnt = 0;
        pulse_start();
        repeat (5) step();
        check_eq("t1_valid_cycles", 32'(valid_cnt), 32'd3);
        check_eq("t1_train", 32'(TRAIN_CNT), 32'd2);
        check_eq("t1_out", 32'(OUTSTANDING), 32'd1);
        check_eq("t1_busy_drain", 32'(BUSY), 32'd1);
        check_eq("t1_sample_left", 32'(exp_s.size()), 32'd0);
        drive_done(8'd30, 8'd2, 8'd0, 1);
        check_eq("t1_out_after", 32'(OUTSTANDING), 32'd0);
        check_eq("t1_fin_early", 32'(FINISHED), 32'd0);
        step();
        check_eq("t1_finished", 32'(FINISHED), 32'd1);
        check_eq("t1_busy_end", 32'(BUSY), 32'd0);
        check_eq("t1_rd_data_const", 32'(RD_DATA), 32'({1'b1, 8'd30, 8'd2, 8'd0}));
        step();
        check_eq("t1_fin_pulse", 32'(FINISHED), 32'd0);
        read_result("t1_result");

        // Stalled READY pattern 1,0,0,1,1
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        push_sample(8'd1, 8'd2, 1'b0, 1);
        push_sample(8'd3, 8'd4, 1'b0, 1);
        push_sample(8'd5, 8'd6, 1'b0, 1);
        valid_cnt = 0;
        x0 = xfer_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            bus.ready = pat[i];
            if (i == 0) check_eq("t2_xi_first", 32'(bus.xi), 32'd1);
            if (i == 1 || i == 2) check_eq("t2_xi_stall", 32'(bus.xi), 32'd3);
            step();
        end
        check_eq("t2_xfers", 32'(xfer_cnt - x0), 32'd3);
        step();
        step();
        check_eq("t2_finished", 32'(FINISHED), 32'd1);
        check_eq("t2_cycles", CYCLES, 32'd7);
        check_eq("t2_valid_cycles", 32'(valid_cnt), 32'd5);
        check_eq("t2_train", 32'(TRAIN_CNT), 32'd3);
        step();
        check_eq("t2_cycles_hold", CYCLES, 32'd7);

        // Prediction before any training
        push_sample(8'd5, 8'd0, 1'b1, 1);
        bus.ready = 1'b1;
        pulse_start();
        repeat (3) step();
        check_eq("t3_train", 32'(TRAIN_CNT), 32'd0);
        check_eq("t3_out", 32'(OUTSTANDING), 32'd1);
        drive_done(8'd7, 8'd0, 8'd0, 1);
        wait_idle(20);
        read_result("t3_result");
        check_eq("t3_res_empty", 32'(RES_EMPTY), 32'd1);

        // Sample FIFO overflow
        bus.ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            push_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1);
        end
        check_eq("t4_full", 32'(FULL), 32'd1);
        check_eq("t4_err_before", 32'(ERR), 32'd0);
        push_sample(8'hEE, 8'hEE, 1'b0, 0);
        check_eq("t4_err", 32'(ERR), 32'd1);
        check_eq("t4_full_after", 32'(FULL), 32'd1);
        bus.ready = 1'b1;
        x0 = xfer_cnt;
        pulse_start();
        wait_idle(200);
        check_eq("t4_xfers", 32'(xfer_cnt - x0), 32'(DEPTH));
        check_eq("t4_train", 32'(TRAIN_CNT), 32'(DEPTH));
        check_eq("t4_full_drained", 32'(FULL), 32'd0);
        check_eq("t4_err_sticky", 32'(ERR), 32'd1);

        // Result FIFO overflow, DONE with nothing outstanding
        do_reset();
        check_eq("t5_err_cleared", 32'(ERR), 32'd0);
        for (int i = 0; i < int'(RES_DEPTH); i++) begin
            drive_done(8'(i + 40), 8'(i), 8'(i * 3), 1);
        end
        check_eq("t5_err_before", 32'(ERR), 32'd0);
        check_eq("t5_out_floor", 32'(OUTSTANDING), 32'd0);
        drive_done(8'hAA, 8'hBB, 8'hCC, 0);
        check_eq("t5_err", 32'(ERR), 32'd1);
        for (int i = 0; i < int'(RES_DEPTH); i++) read_result("t5_result");
        check_eq("t5_res_empty", 32'(RES_EMPTY), 32'd1);
        RD_EN = 1'b1;
        step();
        RD_EN = 1'b0;
        check_eq("t5_rd_empty_ignored", 32'(RES_EMPTY), 32'd1);
        check_eq("t5_rd_data_zero", 32'(RD_DATA), 32'd0);

        // Reset in the middle of streaming
        do_reset();
        drive_done(8'h11, 8'h22, 8'h33, 0);
        bus.ready = 1'b0;
        for (int i = 0; i < 10; i++) push_sample(8'(i + 1), 8'(i + 2), 1'b0, 1);
        pulse_start();
        step();
        check_eq("t6_busy", 32'(BUSY), 32'd1);
        check_eq("t6_valid", 32'(bus.valid), 32'd1);
        check_eq("t6_res_nonempty", 32'(RES_EMPTY), 32'd0);
        RESET_N = 1'b0;
        #1;
        check_eq("t6_async_valid", 32'(bus.valid), 32'd0);
        check_eq("t6_async_xi", 32'(bus.xi), 32'(idle_x));
        check_eq("t6_async_busy", 32'(BUSY), 32'd0);
        check_eq("t6_async_res_empty", 32'(RES_EMPTY), 32'd1);
        check_eq("t6_async_cycles", CYCLES, 32'd0);
        exp_s.delete();
        exp_r.delete();
        step();
        RESET_N = 1'b1;
        step();
        check_eq("t6_busy_after", 32'(BUSY), 32'd0);
        check_eq("t6_res_empty_after", 32'(RES_EMPTY), 32'd1);
        bus.ready = 1'b1;
        x0 = xfer_cnt;
        pulse_start();
        wait_idle(20);
        check_eq("t6_no_stale_xfer", 32'(xfer_cnt - x0), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
